bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock.

---
 rtl/bin_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Produces DIGITS packed BCD nibbles for the downstream seven-segment decoders.
// A start/busy/done handshake controls it, and the result holds between conversions.
// Values above 10^DIGITS-1 saturate to all 9s and raise overflow.
// Optional feature macro: BCD_BLANK_EN replaces leading-zero digits with 4'hF (blank).
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [BIN_W-1:0] shreg;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    result;
  logic [CW-1:0]    cnt;
  logic             ovf;

  // Add 3 to every scratch nibble that is 5 or more; nibbles are independent, with no carry between them
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = scratch[4*i +: 4];
    end
  end

`ifdef BCD_BLANK_EN
  logic lead;

  // Blank leading zero digits from the MS digit down; stop at the first nonzero digit and never blank the ones digit
  always_comb begin
    result = scratch;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (scratch[4*i +: 4] == 4'h0))
        result[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end
`else
  assign result = scratch;
`endif

  assign busy = (state == S_SHIFT);

  // Control FSM and datapath: capture, BIN_W shift steps, then publish the result for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {scratch, shreg} <= {adj[SW-2:0], shreg, 1'b0};
          ovf              <= ovf | adj[SW-1];
          cnt              <= cnt + CW'(1);
          if (cnt == CW'(BIN_W - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          bcd      <= ovf ? {DIGITS{4'h9}} : result;
          overflow <= ovf;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed, scoreboard-based bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
// The expected result is pushed when a conversion is requested and popped when done pulses.
// It honours the BCD_BLANK_EN macro so that it matches either build.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  bin_to_bcd_seq #(
    .BIN_W (14),
    .DIGITS(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .overflow(overflow)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: {bcd, overflow} from decimal arithmetic
  function automatic logic [16:0] model(input int v);
    logic [15:0] r;
    bit          lead;
    if (v > 9999) return {16'h9999, 1'b1};
    r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`ifdef BCD_BLANK_EN
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return {r, 1'b0};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // request a conversion; returns at the negedge right after the accepting edge
  task automatic applyStimulus(input int v, input bit track);
    @(negedge clk);
    bin   = 14'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (track) sb.push_back(model(v));
  endtask

  // wait (bounded) for done, check latency, busy length, result and pulse width
  task automatic checkOutput(input int expLat, input int expBusy);
    int          cycles  = 0;
    int          busyCnt = 0;
    logic [16:0] exp;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    checkValue("latency", cycles, expLat);
    checkValue("busy_cycles", busyCnt, expBusy);
    if (done === 1'b1) begin
      checkValue("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checkValue("bcd", bcd, exp[16:1]);
        checkValue("overflow", overflow, exp[0]);
      end
    end
    @(negedge clk);
    checkValue("done_pulse", done, 0);
  endtask

  // count done pulses over a window, where none are expected
  task automatic checkNoDone(input string tag, input int window);
    int n = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    checkValue(tag, n, 0);
  endtask

  // directed sequence
  initial begin
    logic [16:0] e;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    checkValue("rst_busy", busy, 0);
    checkValue("rst_done", done, 0);
    checkValue("rst_bcd", bcd, 0);
    checkValue("rst_ovf", overflow, 0);
    rst = 1'b0;

    // basic conversions
    applyStimulus(0, 1);    checkOutput(15, 14);
    applyStimulus(1234, 1); checkOutput(15, 14);
    applyStimulus(9999, 1); checkOutput(15, 14);

    // result holds while idle, even if bin changes
    bin = 14'd16383;
    repeat (5) @(negedge clk);
    e = model(9999);
    checkValue("hold_bcd", bcd, e[16:1]);
    checkValue("hold_ovf", overflow, 0);

    // saturation, then recovery
    applyStimulus(10000, 1); checkOutput(15, 14);
    applyStimulus(16383, 1); checkOutput(15, 14);
    applyStimulus(7, 1);     checkOutput(15, 14);

    // starts while busy are ignored
    applyStimulus(42, 1);
    bin   = 14'd5555;
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    checkOutput(3, 2);
    checkNoDone("no_queued_start", 25);

    // reset mid-conversion aborts
    applyStimulus(321, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkValue("abort_busy", busy, 0);
    checkValue("abort_bcd", bcd, 0);
    checkValue("abort_ovf", overflow, 0);
    checkNoDone("abort_no_done", 25);
    applyStimulus(321, 1); checkOutput(15, 14);

    // blanking-relevant patterns (blank or plain, depending on build)
    applyStimulus(1005, 1);  checkOutput(15, 14);
    applyStimulus(12000, 1); checkOutput(15, 14);
    applyStimulus(42, 1);    checkOutput(15, 14);
    applyStimulus(0, 1);     checkOutput(15, 14);

    checkValue("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
